// File: rtl/pacman_vram_arbiter.sv
// pacman_vram_arbiter: Z80 / GPU sharing of the single-port video RAM.
// Define VRAM_RAW_FWD_EN to serve reads that hit the posted write buffer.
module pacman_vram_arbiter #(
   parameter int          ADDR_W    = 11,
   parameter int          DATA_W    = 8,
   parameter logic [15:0] BASE_ADDR = 16'h4000,
   parameter int          MAX_STALL = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [15:0]       cpu_addr,
   input  logic              cpu_mreq_n,
   input  logic              cpu_rd_n,
   input  logic              cpu_wr_n,
   input  logic [DATA_W-1:0] cpu_dout,
   output logic [DATA_W-1:0] cpu_di,
   output logic              cpu_di_valid,
   output logic              cpu_wait_n,
   input  logic              gpu_req,
   input  logic [ADDR_W-1:0] gpu_addr,
   output logic              gpu_ack,
   output logic [DATA_W-1:0] gpu_data,
   output logic              gpu_data_valid,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout,
   output logic              conflict
);

   typedef enum logic [1:0] {R_IDLE, R_REQ, R_DATA, R_HOLD} rd_state_t;

   localparam logic [3:0] STALL_MAX = 4'(MAX_STALL);

   rd_state_t         rstate, rstate_nx;
   logic              cpu_sel, cpu_sel_q;
   logic              new_acc, new_rd, new_wr;
   logic              wb_full, wr_pend;
   logic [ADDR_W-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;
   logic [3:0]        stall_cnt;
   logic              rd_pend, cpu_pend, force_cpu;
   logic              g_gpu, g_wb, g_rd, cap_wr, fwd;
   logic              rd_wait, wr_wait, ld_di;
   logic [DATA_W-1:0] di_nx, gpu_data_q;

   assign cpu_sel = ~cpu_mreq_n
                  & (cpu_addr[15:ADDR_W] == BASE_ADDR[15:ADDR_W])
                  & (~cpu_rd_n | ~cpu_wr_n);
   assign new_acc = cpu_sel & ~cpu_sel_q;
   assign new_wr  = new_acc & ~cpu_wr_n;
   assign new_rd  = new_acc & ~cpu_rd_n & cpu_wr_n;

`ifdef VRAM_RAW_FWD_EN
   assign fwd = new_rd & wb_full
              & (cpu_addr[ADDR_W-1:0] == wb_addr);
`else
   assign fwd = 1'b0;
`endif

   // Per-cycle grant: GPU, then buffer drain, then read; starved CPU forced in.
   always_comb begin
      rd_pend   = (rstate == R_REQ) & cpu_sel;
      cpu_pend  = wb_full | rd_pend;
      force_cpu = cpu_pend & (stall_cnt == STALL_MAX);
      g_gpu     = reset_n & gpu_req & ~force_cpu;
      g_wb      = reset_n & ~g_gpu & wb_full;
      g_rd      = reset_n & ~g_gpu & ~wb_full & rd_pend;
      cap_wr    = (new_wr | wr_pend) & (~wb_full | g_wb);
      ram_en    = g_gpu | g_wb | g_rd;
      ram_we    = g_wb;
      ram_din   = g_wb ? wb_data : '0;
      ram_addr  = '0;
      unique case (1'b1)
         g_gpu:   ram_addr = gpu_addr;
         g_wb:    ram_addr = wb_addr;
         g_rd:    ram_addr = cpu_addr[ADDR_W-1:0];
         default: ram_addr = '0;
      endcase
      gpu_ack  = g_gpu;
      conflict = reset_n & gpu_req & cpu_pend;
   end

   // Read FSM next state, cpu_di load and Z80 wait generation.
   always_comb begin
      rstate_nx = rstate;
      ld_di     = 1'b0;
      di_nx     = ram_dout;
      unique case (rstate)
         R_IDLE: begin
            if (fwd) begin
               ld_di     = 1'b1;
               di_nx     = wb_data;
               rstate_nx = R_HOLD;
            end else if (new_rd) begin
               rstate_nx = R_REQ;
            end
         end
         R_REQ: begin
            if (!cpu_sel)  rstate_nx = R_IDLE;
            else if (g_rd) rstate_nx = R_DATA;
         end
         R_DATA: begin
            if (!cpu_sel) begin
               rstate_nx = R_IDLE;
            end else begin
               ld_di     = 1'b1;
               rstate_nx = R_HOLD;
            end
         end
         R_HOLD: begin
            if (!cpu_sel) rstate_nx = R_IDLE;
         end
         default: rstate_nx = R_IDLE;
      endcase
      rd_wait    = ((rstate == R_IDLE) & new_rd & ~fwd)
                 | (rstate == R_REQ);
      wr_wait    = (new_wr | wr_pend) & wb_full & ~g_wb;
      cpu_wait_n = ~reset_n | ~(rd_wait | wr_wait);
   end

   // Bus-cycle edge detect, posted write buffer and held write request.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cpu_sel_q <= 1'b0;
         wb_full   <= 1'b0;
         wr_pend   <= 1'b0;
         wb_addr   <= '0;
         wb_data   <= '0;
      end else begin
         cpu_sel_q <= cpu_sel;
         wr_pend   <= (new_wr | wr_pend) & ~cap_wr & cpu_sel;
         if (cap_wr) begin
            wb_full <= 1'b1;
            wb_addr <= cpu_addr[ADDR_W-1:0];
            wb_data <= cpu_dout;
         end else if (g_wb) begin
            wb_full <= 1'b0;
         end
      end
   end

   // Starvation counter: counts denied CPU cycles, saturating.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt <= '0;
      end else if (g_wb | g_rd | ~cpu_pend) begin
         stall_cnt <= '0;
      end else if (stall_cnt != STALL_MAX) begin
         stall_cnt <= stall_cnt + 4'd1;
      end
   end

   // Read FSM state and CPU read data return.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rstate       <= R_IDLE;
         cpu_di       <= '0;
         cpu_di_valid <= 1'b0;
      end else begin
         rstate       <= rstate_nx;
         cpu_di_valid <= ld_di;
         if (ld_di) cpu_di <= di_nx;
      end
   end

   // GPU read return: live RAM data on the valid cycle, held afterwards.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         gpu_data_valid <= 1'b0;
         gpu_data_q     <= '0;
      end else begin
         gpu_data_valid <= g_gpu;
         if (gpu_data_valid) gpu_data_q <= ram_dout;
      end
   end

   assign gpu_data = gpu_data_valid ? ram_dout : gpu_data_q;

endmodule

// File: doc/pacman_vram_arbiter.md
Name: pacman_vram_arbiter

Overview:
- Shares the single-port video RAM (tile/palette framebuffer, 0x4000-0x47FF) between the Z80 bus and the GPU tile/palette fetch engine.
- GPU fetches have priority, bounded by a starvation limit. CPU writes are posted through a one-entry buffer.
- CPU reads stall the Z80 through wait_n until data returns.
- Replaces the free-running conflict handling at the framebuffer port.

Parameters:
- ADDR_W, 11, video RAM word address width.
- DATA_W, 8, data width.
- BASE_ADDR, 16'h4000, CPU base address of video RAM; must be aligned to 2^ADDR_W.
- MAX_STALL, 4, consecutive cycles a pending CPU access may lose before it is forced to win (range 1..15).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cpu_addr  in  16  Z80 address bus
- cpu_mreq_n  in  1  Z80 memory request
- cpu_rd_n  in  1  Z80 read strobe
- cpu_wr_n  in  1  Z80 write strobe
- cpu_dout  in  DATA_W  Z80 write data
- cpu_di  out  DATA_W  read data to CPU data-in mux
- cpu_di_valid  out  1  selects cpu_di in CPU data-in mux; one-cycle pulse
- cpu_wait_n  out  1  Z80 wait (low = stall)
- gpu_req  in  1  GPU fetch request, held until acked
- gpu_addr  in  ADDR_W  GPU fetch address
- gpu_ack  out  1  GPU request granted this cycle
- gpu_data  out  DATA_W  fetched data
- gpu_data_valid  out  1  gpu_data valid; cycle after gpu_ack
- ram_en  out  1  RAM enable
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_din  out  DATA_W  RAM write data
- ram_dout  in  DATA_W  RAM read data, 1-cycle latency
- conflict  out  1  GPU and CPU contended this cycle

Behaviour:
- Interface: one clock clk; reset_n asynchronous, active-low.
- Decode: cpu_sel = ~cpu_mreq_n & (cpu_addr[15:ADDR_W] == BASE_ADDR[15:ADDR_W]) & (~cpu_rd_n | ~cpu_wr_n).
  - A new access is cpu_sel high while registered cpu_sel_q is low.
  - Each bus cycle is serviced exactly once.
- Reset values:
  - cpu_wait_n=1; all other outputs 0.
  - Write buffer empty; stall counter 0; read FSM R_IDLE.
- Write buffer:
  - A new write with the buffer empty captures {addr[ADDR_W-1:0], cpu_dout} and sets full. No wait.
  - A new write with the buffer full drives cpu_wait_n low combinationally in the same cycle. Wait stays low until the buffer drains; capture happens that same cycle.
- Read FSM:
  - R_IDLE -> R_REQ on a new read; cpu_wait_n low combinationally from that cycle.
  - R_REQ -> R_DATA when granted.
  - R_DATA: register ram_dout into cpu_di, pulse cpu_di_valid, drive cpu_wait_n=1, then -> R_HOLD.
  - R_HOLD -> R_IDLE when cpu_sel drops. cpu_di holds its value until the next read completes.
  - cpu_sel dropping in R_REQ or R_DATA: abort to R_IDLE, no cpu_di_valid, result discarded.
- Grant priority per cycle:
  - Order: GPU, then write-buffer drain, then CPU read.
  - Exception: when stall counter == MAX_STALL, CPU (buffer first, then read) wins and gpu_ack=0. GPU holds gpu_req.
  - A read pending while the buffer is full waits until the buffer drains, which preserves order.
- Stall counter:
  - Increments each cycle a CPU access is pending and denied.
  - Clears on any CPU grant, or when nothing is pending. Saturates at MAX_STALL.
- RAM drive: a grant drives ram_en=1 with the matching ram_addr, ram_we and ram_din in the same cycle.
  - ram_we=1 only for a buffer drain.
  - ram_en=0 with no grant.
- GPU read: gpu_data_valid=1 the cycle after gpu_ack, with gpu_data=ram_dout; otherwise gpu_data holds its previous value.
- conflict: 1 in any cycle where gpu_req and a CPU access are both pending.
- Reset mid-operation: immediate abort; buffered write lost; wait released.

Optional Feature:
- Macro: VRAM_RAW_FWD_EN.
- Defined: a read whose address matches the full write buffer is served from the buffer without a RAM access. cpu_di_valid follows one cycle after the decode, and the buffer still drains normally.
- Undefined: such a read waits for the drain like any other read.

Test Plan:
- Reset: assert reset_n=0 mid-read -> cpu_wait_n=1, ram_en=0, gpu_ack=0, buffer empty after reset.
- Posted write: CPU writes 0x5A to 0x4123, GPU idle -> no wait cycle; next cycle ram_we=1, ram_addr=0x123, ram_din=0x5A.
- CPU read with GPU idle: RAM[0x010]=0x3C, CPU reads 0x4010 -> wait low 2 cycles, then cpu_di=0x3C with a single cpu_di_valid pulse.
- Starvation, MAX_STALL=4: gpu_req held high continuously, CPU read pending -> exactly 4 gpu_acks, then a CPU grant; conflict high throughout the contention.
- Back-to-back writes: 0x11@0x4000 then 0x22@0x4001 with GPU requesting -> second write waits; RAM ends with 0x11, 0x22 in that order.
- Read-after-write to 0x4200, GPU busy -> read returns the new value. With VRAM_RAW_FWD_EN the read completes before the drain; without it the read completes after the drain.
